// File: rtl/mode_select_fsm.sv
// Front-panel mode selector: idle segment chase, release-triggered mode entry, short-press cycling, long-press exit.
// Optional MODE_SELECT_BOUNCE_EN makes the idle chase ping-pong instead of wrapping.
module mode_select_fsm #(
  parameter int unsigned g_NUM_MODES   = 3,
  parameter int unsigned g_ANIM_DELAY  = 4166666,
  parameter int unsigned g_ANIM_LENGTH = 6,
  parameter int unsigned g_HOLD_DELAY  = 75000000
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic [g_NUM_MODES:0]   i_Switches,
  output logic [1:0]             o_State,
  output logic [2:0]             o_Mode,
  output logic                   o_Mode_Start,
  output logic [6:0]             o_Segments
);

  localparam int unsigned SW_W  = g_NUM_MODES + 1;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned MODE_W = 3;

  localparam logic [CNT_W-1:0]  ANIM_LAST = CNT_W'(g_ANIM_DELAY - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(g_HOLD_DELAY - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(g_ANIM_LENGTH - 1);
  localparam logic [IDX_W-1:0]  IDX_EXIT  = IDX_W'(6);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(g_NUM_MODES - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACTIVE    = 2'd1,
    ST_EXIT_WAIT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [MODE_W-1:0]  mode_q, mode_d;
  logic               start_q, start_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_step;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SW_W-1:0]    sw_q;
  logic [6:0]         seg_q;
`ifdef MODE_SELECT_BOUNCE_EN
  logic               dir_up_q, dir_up_d, dir_up_step;
`endif

  logic [SW_W-1:0]        falls_c;
  logic [g_NUM_MODES-1:0] mode_falls_c;
  logic                   any_mode_fall_c;
  logic                   hold_c;
  logic                   hold_fall_c;
  logic [MODE_W-1:0]      low_mode_c;

  // Release edges: switch was pressed last cycle and is released now
  assign falls_c         = sw_q & ~i_Switches;
  assign mode_falls_c    = falls_c[g_NUM_MODES-1:0];
  assign any_mode_fall_c = |mode_falls_c;
  assign hold_c          = i_Switches[g_NUM_MODES];
  assign hold_fall_c     = falls_c[g_NUM_MODES];

  // Lowest released mode switch wins
  always_comb begin
    low_mode_c = '0;
    for (int i = int'(g_NUM_MODES) - 1; i >= 0; i--) begin
      if (mode_falls_c[i]) low_mode_c = MODE_W'(i);
    end
  end

  // Next chase position for one animation step
  always_comb begin
    idx_step = idx_q;
`ifdef MODE_SELECT_BOUNCE_EN
    dir_up_step = dir_up_q;
    if (IDX_LAST == '0) begin
      idx_step = '0;
    end else if (dir_up_q) begin
      if (idx_q == IDX_LAST) begin
        idx_step    = idx_q - IDX_W'(1);
        dir_up_step = 1'b0;
      end else begin
        idx_step = idx_q + IDX_W'(1);
      end
    end else begin
      if (idx_q == '0) begin
        idx_step    = IDX_W'(1);
        dir_up_step = 1'b1;
      end else begin
        idx_step = idx_q - IDX_W'(1);
      end
    end
`else
    idx_step = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
`endif
  end

  // Next-state and register update logic
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    start_d = 1'b0;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
`ifdef MODE_SELECT_BOUNCE_EN
    dir_up_d = dir_up_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_mode_fall_c) begin
          state_d = ST_ACTIVE;
          mode_d  = low_mode_c;
          start_d = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == ANIM_LAST) begin
          cnt_d = '0;
          idx_d = idx_step;
`ifdef MODE_SELECT_BOUNCE_EN
          dir_up_d = dir_up_step;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACTIVE: begin
        if (hold_c) begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_EXIT_WAIT;
            idx_d   = IDX_EXIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (hold_fall_c) begin
          mode_d  = (mode_q == MODE_LAST) ? '0 : mode_q + MODE_W'(1);
          start_d = 1'b1;
          cnt_d   = '0;
        end else if (any_mode_fall_c) begin
          mode_d  = low_mode_c;
          start_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = '0;
        end
      end
      ST_EXIT_WAIT: begin
        if (!hold_c) begin
          state_d = ST_IDLE;
          mode_d  = '0;
          idx_d   = '0;
          cnt_d   = '0;
`ifdef MODE_SELECT_BOUNCE_EN
          dir_up_d = 1'b1;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        mode_d  = '0;
        idx_d   = '0;
        cnt_d   = '0;
`ifdef MODE_SELECT_BOUNCE_EN
        dir_up_d = 1'b1;
`endif
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      start_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      sw_q    <= '0;
      seg_q   <= 7'b0000001;
`ifdef MODE_SELECT_BOUNCE_EN
      dir_up_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      start_q <= start_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sw_q    <= i_Switches;
      seg_q   <= 7'(1) << idx_d;
`ifdef MODE_SELECT_BOUNCE_EN
      dir_up_q <= dir_up_d;
`endif
    end
  end

  assign o_State      = 2'(state_q);
  assign o_Mode       = mode_q;
  assign o_Mode_Start = start_q;
  assign o_Segments   = seg_q;

endmodule

// File: tb/tb_mode_select_fsm.sv
// Bench for mode_select_fsm: directed scenarios then random switch activity against a behavioural model.
module tb_mode_select_fsm;

  localparam int NM = 3;
  localparam int AD = 4;
  localparam int AL = 6;
  localparam int HD = 10;

  logic       clk = 1'b0;
  logic       rst_l;
  logic [3:0] sw;
  logic [1:0] state;
  logic [2:0] mode;
  logic       mode_start;
  logic [6:0] segments;

  always #5 clk = ~clk;

  mode_select_fsm #(
    .g_NUM_MODES  (NM),
    .g_ANIM_DELAY (AD),
    .g_ANIM_LENGTH(AL),
    .g_HOLD_DELAY (HD)
  ) dut (
    .i_Clk       (clk),
    .i_Rst_L     (rst_l),
    .i_Switches  (sw),
    .o_State     (state),
    .o_Mode      (mode),
    .o_Mode_Start(mode_start),
    .o_Segments  (segments)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: state, mode, strobe, cycles spent in IDLE, consecutive hold samples in ACTIVE
  int         m_state;
  int         m_mode;
  int         m_start;
  int         m_ticks;
  int         m_run;
  logic [3:0] m_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // Chase position after a given number of idle cycles
  function automatic int anim_idx(input int ticks);
    int steps;
    int period;
    int r;
    steps = ticks / AD;
`ifdef MODE_SELECT_BOUNCE_EN
    if (AL == 1) return 0;
    period = 2 * (AL - 1);
    r = steps % period;
    return (r < AL) ? r : period - r;
`else
    period = AL;
    r = steps % period;
    return r;
`endif
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_mode  = 0;
    m_start = 0;
    m_ticks = 0;
    m_run   = 0;
    m_prev  = '0;
  endtask

  task automatic model_step(input logic [3:0] s);
    logic [3:0] fell;
    int low;
    fell = m_prev & ~s;
    low = -1;
    for (int i = NM - 1; i >= 0; i--) if (fell[i]) low = i;
    m_start = 0;
    case (m_state)
      0: begin
        if (low >= 0) begin
          m_state = 1; m_mode = low; m_start = 1; m_run = 0;
        end else begin
          m_ticks++;
        end
      end
      1: begin
        if (s[NM]) begin
          m_run++;
          if (m_run == HD) m_state = 2;
        end else if (fell[NM]) begin
          m_mode = (m_mode + 1) % NM; m_start = 1; m_run = 0;
        end else if (low >= 0) begin
          m_mode = low; m_start = 1; m_run = 0;
        end else begin
          m_run = 0;
        end
      end
      default: begin
        if (!s[NM]) begin
          m_state = 0; m_mode = 0; m_ticks = 0;
        end
      end
    endcase
    m_prev = s;
  endtask

  task automatic check_all();
    logic [6:0] exp_seg;
    exp_seg = (m_state == 2) ? 7'h40 : 7'(7'(1) << anim_idx(m_ticks));
    check("state", 32'(state), 32'(m_state));
    check("mode", 32'(mode), 32'(m_mode));
    check("mode_start", 32'(mode_start), 32'(m_start));
    check("segments", 32'(segments), 32'(exp_seg));
  endtask

  task automatic cycle(input logic [3:0] s);
    sw = s;
    @(posedge clk);
    model_step(s);
    #1;
    check_all();
  endtask

  initial begin
    logic [3:0] p;
    rst_l = 1'b0;
    sw    = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_start", 32'(mode_start), 32'd0);
    check("rst_segments", 32'(segments), 32'h01);
    @(negedge clk);
    rst_l = 1'b1;

    // Idle chase
    repeat (30) cycle(4'b0000);

    // Simultaneous release of bits 0 and 2: lowest wins
    cycle(4'b0101); cycle(4'b0101);
    cycle(4'b0000); cycle(4'b0000); cycle(4'b0000);

    // Select mode 2, then short press advances to mode 0
    cycle(4'b0100); cycle(4'b0000);
    repeat (3) cycle(4'b1000);
    cycle(4'b0000); cycle(4'b0000);

    // Long press to EXIT_WAIT, keep holding, then release back to IDLE
    repeat (10) cycle(4'b1000);
    repeat (5) cycle(4'b1000);
    repeat (7) cycle(4'b0000);

    // Interrupted long presses only advance the mode
    cycle(4'b0010); cycle(4'b0000);
    repeat (9) cycle(4'b1000);
    cycle(4'b0000);
    repeat (9) cycle(4'b1000);
    cycle(4'b0000); cycle(4'b0000);

    // Async reset while in EXIT_WAIT
    repeat (10) cycle(4'b1000);
    #3 rst_l = 1'b0;
    #1;
    model_reset();
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_mode", 32'(mode), 32'd0);
    check("async_rst_start", 32'(mode_start), 32'd0);
    check("async_rst_segments", 32'(segments), 32'h01);
    sw = '0;
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_l = 1'b1;
    repeat (3) cycle(4'b0000);

    // Random switch activity
    repeat (250) begin
      case ($urandom_range(0, 3))
        0: repeat ($urandom_range(1, 12)) cycle(4'b0000);
        1: begin
          p = 4'($urandom_range(1, 7));
          repeat ($urandom_range(1, 2)) cycle(p);
          cycle(4'b0000);
        end
        2: begin
          repeat ($urandom_range(1, 13)) cycle(4'b1000);
          repeat ($urandom_range(1, 3)) cycle(4'b0000);
        end
        default: begin
          repeat ($urandom_range(1, 12)) cycle(4'b1000 | 4'($urandom_range(0, 7)));
          cycle(4'b1000);
          cycle(4'b0000);
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mode_select_fsm.md
# mode_select_fsm

Parametrised front-panel mode selector for the seven-segment projects. Provides a configurable number of mode-entry switches plus one dedicated hold/back switch, an idle segment-chase animation, and long-press exit with a release-wait state. Adds short-press mode cycling and a one-cycle mode-start strobe. Drives one seven-segment digit directly and reports state and mode to the downstream mode logic.

## Interface
- g_NUM_MODES, 3: number of mode-entry switches, 1..7; mode index range 0..g_NUM_MODES-1
- g_ANIM_DELAY, 4166666: cycles per animation step; must be ≥ 1
- g_ANIM_LENGTH, 6: number of chase segments (bits 0..g_ANIM_LENGTH-1), 1..6
- g_HOLD_DELAY, 75000000: consecutive cycles the hold switch must be high to exit; must be ≥ 2
- i_Clk  in  1  system clock
- i_Rst_L  in  1  asynchronous active-low reset
- i_Switches  in  g_NUM_MODES+1  bits 0..g_NUM_MODES-1 are mode switches; bit g_NUM_MODES is the hold switch; pressed = 1
- o_State  out  2  0 = IDLE, 1 = ACTIVE, 2 = EXIT_WAIT
- o_Mode  out  3  current mode index; valid in ACTIVE
- o_Mode_Start  out  1  one-cycle strobe on every mode entry or change
- o_Segments  out  7  one-hot segment drive; bit 6 is the middle segment

## Operation
- Reset (i_Rst_L low, async): State IDLE, Mode 0, Mode_Start 0, segment index 0 (o_Segments = 7'b0000001), delay counter 0, switch history register 0.
- Switch history r_Sw holds previous-cycle i_Switches. Falling edge on bit k = i_Switches[k]==0 && r_Sw[k]==1. Edges are detected on release.
- IDLE: falling edge on mode switch k → ACTIVE, Mode = k, Mode_Start pulse, delay counter cleared. On simultaneous edges, the lowest k wins. With no edge, the delay counter increments. When it equals g_ANIM_DELAY-1, it clears and the segment index advances. At index g_ANIM_LENGTH-1 it wraps to 0 (see Configuration). Hold switch is ignored in IDLE.
- ACTIVE:
  - Hold switch high: the delay counter increments. When it reaches g_HOLD_DELAY-1, the next cycle moves to EXIT_WAIT and the segment index becomes 6. Mode switch edges are ignored while the hold switch is high.
  - Hold switch falling edge with counter < g_HOLD_DELAY-1 (short press): Mode = (Mode+1) mod g_NUM_MODES, Mode_Start pulse, counter cleared.
  - Hold switch low, falling edge on mode switch k: Mode = k, Mode_Start pulse. This applies even when k equals the current mode, and lowest k wins.
  - Hold switch low otherwise: counter held at 0.
  - The segment index is frozen during ACTIVE.
- EXIT_WAIT: o_Segments = 7'b1000000. Waits for the hold switch to be low (level, not edge). Then → IDLE with counter 0, segment index 0, Mode 0. The release does not trigger a short-press mode advance.
- Illegal State encoding (3) → IDLE on next clock.
- o_Segments = 7'd1 << segment index, registered-equivalent: index updates take effect on the same edge.

## Timing
- Switch-to-state latency: State, Mode and Mode_Start update on the first clock edge where a falling edge is seen. That is one edge after the input drops, relative to r_Sw.
- Mode_Start is high for exactly one cycle, in the cycle after that edge.
- Animation period: exactly g_ANIM_DELAY cycles per step. The first step after reset or after re-entering IDLE comes g_ANIM_DELAY edges later.
- Long press: the hold switch must be high for g_HOLD_DELAY consecutive sampled cycles, counted from the first cycle high in ACTIVE. Any low sample restarts the count.
- The delay counter is 32 bits with no wrap. Thresholds are compared for equality. Parameters above 2^32-1 are illegal.
- Reset asserted mid-operation, in any state, returns all outputs to reset values immediately. No strobe is issued on reset release.
- Inputs are assumed synchronous and debounced upstream.

## Configuration
- MODE_SELECT_BOUNCE_EN defined: the idle animation ping-pongs 0→g_ANIM_LENGTH-1→0 using a direction flag, which resets to up. With g_ANIM_LENGTH = 1 the index stays 0.
- Undefined: the index wraps from g_ANIM_LENGTH-1 to 0.
- The macro does not affect any other behaviour.

## Test plan
Bench parameters for all scenarios: g_NUM_MODES = 3, g_ANIM_DELAY = 4, g_ANIM_LENGTH = 6, g_HOLD_DELAY = 10.
- Reset, no input for 30 cycles → o_Segments steps 01,02,04,08,10,20,01 every 4 cycles. With BOUNCE_EN: …20,10,08… State stays 0.
- Press/release bits 0 and 2 together → State 1, Mode 0, one Mode_Start pulse, segments frozen.
- In ACTIVE Mode 2, hold switch high for 3 cycles then released → Mode 0, one strobe, State 1.
- In ACTIVE, hold switch high for 10 cycles → State 2, o_Segments 7'h40. Hold for 5 more then release → State 0, Mode 0, o_Segments 01, no strobe.
- In ACTIVE, hold switch high 9 cycles, low 1, high 9 → never reaches EXIT_WAIT. Each release advances Mode.
- Assert i_Rst_L low asynchronously mid-EXIT_WAIT → all outputs return to reset values before the next clock edge.
